// File: rtl/ahb_pkg.sv
// Shared AHB-Lite master types: transfer/size encodings, RISC-V funct3 codes,
// master FSM states and the lane steering / load extension helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } mst_state_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] FN3_B  = 3'b000;
    localparam logic [2:0] FN3_H  = 3'b001;
    localparam logic [2:0] FN3_W  = 3'b010;
    localparam logic [2:0] FN3_BU = 3'b100;
    localparam logic [2:0] FN3_HU = 3'b101;

    function automatic logic fn3_illegal(input logic [2:0] fn3, input logic write);
        logic bad;
        case (fn3)
            FN3_B, FN3_H, FN3_W: bad = 1'b0;
            FN3_BU, FN3_HU:      bad = write;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [2:0] fn3_hsize(input logic [2:0] fn3);
        logic [2:0] sz;
        case (fn3[1:0])
            2'b00:   sz = HSIZE_BYTE;
            2'b01:   sz = HSIZE_HALF;
            default: sz = HSIZE_WORD;
        endcase
        return sz;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] fn3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (fn3[1:0])
            2'b00:   lanes = {4{wdata[7:0]}};
            2'b01:   lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] fn3, input logic [1:0] lane,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{lane, 3'b000} +: 8];
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (fn3)
            FN3_B:   res = {{24{b[7]}}, b};
            FN3_H:   res = {{16{h[15]}}, h};
            FN3_BU:  res = {24'h00_0000, b};
            FN3_HU:  res = {16'h0000, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ahb_addr_decoder.sv
// Region decoder: compares the top address byte with each slave base byte and
// returns a one-hot select (lowest index wins) plus a default-slave flag.
module ahb_addr_decoder #(
    parameter int                      NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*8-1:0] SLV_BASE   = {8'hB0, 8'hA0}
) (
    input  logic [7:0]            addr_top,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  dflt
);

    logic found_s;

    // Priority match: the first region hit masks all higher ones
    always_comb begin
        sel     = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel[i]  = (addr_top == SLV_BASE[8*i +: 8]) & ~found_s;
            found_s = found_s | sel[i];
        end
    end

    assign dflt = ~found_s;

endmodule

// File: rtl/ahb_lite_master.sv
// Single-beat AHB-Lite master bridge for the core load/store/fetch port.
// Define AHB_MISALIGN_TRAP_EN to reject misaligned half/word requests instead of aligning them.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int                      ADDR_W     = 32,
    parameter int                      NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*8-1:0] SLV_BASE   = {8'hB0, 8'hA0}
) (
    input  logic                     hclk,
    input  logic                     hresetn,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_instr,
    input  logic [2:0]               req_fn3,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic                     rsp_err,
    output logic [31:0]              rsp_rdata,
    output logic [ADDR_W-1:0]        haddr,
    output logic [1:0]               htrans,
    output logic                     hwrite,
    output logic [2:0]               hsize,
    output logic [2:0]               hburst,
    output logic [3:0]               hprot,
    output logic [31:0]              hwdata,
    output logic [NUM_SLAVES-1:0]    hsel,
    output logic                     hready,
    input  logic [NUM_SLAVES-1:0]    hreadyout_s,
    input  logic [NUM_SLAVES-1:0]    hresp_s,
    input  logic [NUM_SLAVES*32-1:0] hrdata_s
);

    mst_state_t            state_r;
    htrans_t               htrans_r;
    logic                  req_ready_r, rsp_valid_r, rsp_err_r;
    logic [31:0]           rsp_rdata_r, hwdata_r, wdata_r;
    logic [ADDR_W-1:0]     haddr_r, addr_algn_s;
    logic                  hwrite_r;
    logic [2:0]            hsize_r, fn3_r;
    logic [3:0]            hprot_r;
    logic [NUM_SLAVES-1:0] hsel_r, dsel_r, dec_sel_s;
    logic                  dec_dflt_s, dflt_r, dflt_done_r, reject_s;
    logic                  hready_s, hresp_mux_s;
    logic [31:0]           hrdata_mux_s;

    ahb_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLV_BASE   (SLV_BASE)
    ) u_dec (
        .addr_top (req_addr[ADDR_W-1 -: 8]),
        .sel      (dec_sel_s),
        .dflt     (dec_dflt_s)
    );

`ifdef AHB_MISALIGN_TRAP_EN
    logic misalign_s;

    // Flag half/word requests whose low address bits are not aligned
    always_comb begin
        case (req_fn3[1:0])
            2'b01:   misalign_s = req_addr[0];
            2'b10:   misalign_s = |req_addr[1:0];
            default: misalign_s = 1'b0;
        endcase
    end

    assign reject_s    = fn3_illegal(req_fn3, req_write) | misalign_s;
    assign addr_algn_s = req_addr;
`else
    // Force the low address bits to the access alignment
    always_comb begin
        case (req_fn3[1:0])
            2'b01:   addr_algn_s = {req_addr[ADDR_W-1:1], 1'b0};
            2'b10:   addr_algn_s = {req_addr[ADDR_W-1:2], 2'b00};
            default: addr_algn_s = req_addr;
        endcase
    end

    assign reject_s = fn3_illegal(req_fn3, req_write);
`endif

    // Data-phase response mux: latched slave, or the internal two-cycle ERROR slave
    always_comb begin
        hrdata_mux_s = 32'h0000_0000;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hrdata_mux_s = hrdata_mux_s | (hrdata_s[32*i +: 32] & {32{dsel_r[i]}});
        end
        if (state_r != ST_DATA) begin
            hready_s    = 1'b1;
            hresp_mux_s = 1'b0;
        end else if (dflt_r) begin
            hready_s    = dflt_done_r;
            hresp_mux_s = 1'b1;
        end else begin
            hready_s    = |(hreadyout_s & dsel_r);
            hresp_mux_s = |(hresp_s & dsel_r);
        end
    end

    // Master FSM with registered bus and response outputs
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            htrans_r    <= HTRANS_IDLE;
            haddr_r     <= '0;
            hwrite_r    <= 1'b0;
            hsize_r     <= HSIZE_WORD;
            hprot_r     <= 4'b0000;
            hwdata_r    <= 32'h0000_0000;
            hsel_r      <= '0;
            dsel_r      <= '0;
            dflt_r      <= 1'b0;
            dflt_done_r <= 1'b0;
            fn3_r       <= 3'b000;
            wdata_r     <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        fn3_r   <= req_fn3;
                        wdata_r <= store_lanes(req_fn3, req_wdata);
                        if (reject_s) begin
                            rsp_valid_r <= 1'b1;
                            rsp_err_r   <= 1'b1;
                            rsp_rdata_r <= 32'h0000_0000;
                        end else begin
                            state_r     <= ST_ADDR;
                            req_ready_r <= 1'b0;
                            htrans_r    <= HTRANS_NONSEQ;
                            haddr_r     <= addr_algn_s;
                            hwrite_r    <= req_write;
                            hsize_r     <= fn3_hsize(req_fn3);
                            hprot_r     <= {2'b00, 1'b1, ~req_instr};
                            hsel_r      <= dec_sel_s;
                            dsel_r      <= dec_sel_s;
                            dflt_r      <= dec_dflt_s;
                        end
                    end
                end
                ST_ADDR: begin
                    state_r     <= ST_DATA;
                    htrans_r    <= HTRANS_IDLE;
                    hsel_r      <= '0;
                    hwdata_r    <= wdata_r;
                    dflt_done_r <= 1'b0;
                end
                ST_DATA: begin
                    dflt_done_r <= 1'b1;
                    if (hready_s) begin
                        state_r     <= ST_IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= hresp_mux_s;
                        rsp_rdata_r <= (hresp_mux_s || hwrite_r) ? 32'h0000_0000
                                     : load_extend(fn3_r, haddr_r[1:0], hrdata_mux_s);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b1;
                    htrans_r    <= HTRANS_IDLE;
                    hsel_r      <= '0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_err   = rsp_err_r;
    assign rsp_rdata = rsp_rdata_r;
    assign haddr     = haddr_r;
    assign htrans    = htrans_r;
    assign hwrite    = hwrite_r;
    assign hsize     = hsize_r;
    assign hburst    = 3'b000;
    assign hprot     = hprot_r;
    assign hwdata    = hwdata_r;
    assign hsel      = hsel_r;
    assign hready    = hready_s;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomised self-checking bench for ahb_lite_master with a transaction-level
// reference model and behavioural slaves (wait states, ERROR responses).
module tb_ahb_lite_master;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        req_valid, req_ready, req_write, req_instr;
    logic [2:0]  req_fn3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, haddr, hwdata;
    logic [1:0]  htrans, hsel, hreadyout_s, hresp_s;
    logic        hwrite, hready;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [63:0] hrdata_s;

    int errors = 0;
    int checks = 0;

    ahb_lite_master #(
        .ADDR_W     (32),
        .NUM_SLAVES (2),
        .SLV_BASE   ({8'hB0, 8'hA0})
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_instr   (req_instr),
        .req_fn3     (req_fn3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .haddr       (haddr),
        .htrans      (htrans),
        .hwrite      (hwrite),
        .hsize       (hsize),
        .hburst      (hburst),
        .hprot       (hprot),
        .hwdata      (hwdata),
        .hsel        (hsel),
        .hready      (hready),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata_s    (hrdata_s)
    );

    always #5 hclk = ~hclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic slaves_idle();
        hreadyout_s = 2'b11;
        hresp_s     = 2'b00;
        hrdata_s    = {$urandom, $urandom};
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata,      32'd0);
        check_eq({tag, "_htrans"},    32'(htrans),    32'd0);
        check_eq({tag, "_haddr"},     haddr,          32'd0);
        check_eq({tag, "_hwrite"},    32'(hwrite),    32'd0);
        check_eq({tag, "_hsize"},     32'(hsize),     32'd2);
        check_eq({tag, "_hburst"},    32'(hburst),    32'd0);
        check_eq({tag, "_hprot"},     32'(hprot),     32'd0);
        check_eq({tag, "_hwdata"},    hwdata,         32'd0);
        check_eq({tag, "_hsel"},      32'(hsel),      32'd0);
        check_eq({tag, "_hready"},    32'(hready),    32'd1);
    endtask

    // One request, called just after a negedge; returns just after the negedge of the response cycle.
    task automatic do_xfer(input logic wr, input logic instr, input logic [2:0] fn3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic serr, input logic [31:0] rd);
        int          tgt, nb, w;
        logic        reject, exp_err;
        logic [31:0] aaddr, mask, mult, exp_wd, exp_rd;
        nb     = 1 << fn3[1:0];
        aaddr  = addr - (addr % nb);
        reject = (fn3 == 3'd3) || (fn3 >= 3'd6) || ((fn3 >= 3'd4) && wr);
`ifdef AHB_MISALIGN_TRAP_EN
        if (!reject && (addr % nb) != 0) reject = 1'b1;
`endif
        tgt  = (addr[31:24] == 8'hA0) ? 0 : (addr[31:24] == 8'hB0) ? 1 : -1;
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        mult = (nb == 1) ? 32'h0101_0101 : (nb == 2) ? 32'h0001_0001 : 32'd1;
        exp_wd = (wd & mask) * mult;

        req_valid = 1'b1; req_write = wr; req_instr = instr;
        req_fn3 = fn3; req_addr = addr; req_wdata = wd;
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        #1;
        if (reject) begin
            check_eq("rej_valid",  32'(rsp_valid), 32'd1);
            check_eq("rej_err",    32'(rsp_err),   32'd1);
            check_eq("rej_rdata",  rsp_rdata,      32'd0);
            check_eq("rej_htrans", 32'(htrans),    32'd0);
            check_eq("rej_ready",  32'(req_ready), 32'd1);
            return;
        end
        check_eq("a_htrans", 32'(htrans),    32'd2);
        check_eq("a_haddr",  haddr,          aaddr);
        check_eq("a_hwrite", 32'(hwrite),    32'(wr));
        check_eq("a_hsize",  32'(hsize),     32'(fn3[1:0]));
        check_eq("a_hprot",  32'(hprot),     instr ? 32'd2 : 32'd3);
        check_eq("a_hburst", 32'(hburst),    32'd0);
        check_eq("a_hsel",   32'(hsel),      (tgt < 0) ? 32'd0 : (32'd1 << tgt));
        check_eq("a_hready", 32'(hready),    32'd1);
        check_eq("a_ready",  32'(req_ready), 32'd0);

        w = (tgt < 0) ? 1 : ((serr && waits < 1) ? 1 : waits);
        exp_err = (tgt < 0) || serr;
        for (int k = 0; k <= w; k++) begin
            @(negedge hclk);
            hreadyout_s = 2'($urandom);
            hresp_s     = 2'($urandom);
            hrdata_s    = {$urandom, $urandom};
            if (tgt >= 0) begin
                hreadyout_s[tgt]       = (k == w);
                hresp_s[tgt]           = serr && (k >= w - 1);
                hrdata_s[tgt*32 +: 32] = (k == w) ? rd : $urandom;
            end
            #1;
            check_eq("d_htrans", 32'(htrans),    32'd0);
            check_eq("d_hsel",   32'(hsel),      32'd0);
            check_eq("d_hready", 32'(hready),    32'(k == w));
            check_eq("d_rspv",   32'(rsp_valid), 32'd0);
            if (wr) check_eq("d_hwdata", hwdata, exp_wd);
        end

        exp_rd = (rd >> ((aaddr % 4) * 8)) & mask;
        if (fn3[2] == 1'b0 && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~mask;
        if (exp_err || wr) exp_rd = 32'd0;
        @(negedge hclk);
        slaves_idle();
        #1;
        check_eq("r_valid", 32'(rsp_valid), 32'd1);
        check_eq("r_err",   32'(rsp_err),   32'(exp_err));
        check_eq("r_rdata", rsp_rdata,      exp_rd);
        check_eq("r_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [7:0] top;
        hresetn = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_instr = 1'b0;
        req_fn3 = 3'b010; req_addr = 32'd0; req_wdata = 32'd0;
        slaves_idle();
        repeat (2) @(negedge hclk);
        #1;
        check_reset_vals("rst");
        @(negedge hclk);
        hresetn = 1'b1;
        #1;
        check_reset_vals("post_rst");

        // Directed cases
        do_xfer(1'b0, 1'b0, 3'b010, 32'hA000_0010, 32'h0, 0, 1'b0, 32'hDEAD_BEEF);
        do_xfer(1'b0, 1'b0, 3'b000, 32'hB000_0003, 32'h0, 0, 1'b0, 32'h80FF_FFFF);
        do_xfer(1'b0, 1'b0, 3'b100, 32'hB000_0003, 32'h0, 1, 1'b0, 32'h80FF_FFFF);
        do_xfer(1'b1, 1'b0, 3'b001, 32'hB000_0002, 32'h1234_ABCD, 2, 1'b0, 32'h0);
        do_xfer(1'b0, 1'b0, 3'b010, 32'hC000_0000, 32'h0, 0, 1'b0, 32'h1111_2222);
        do_xfer(1'b0, 1'b0, 3'b011, 32'hA000_0000, 32'h0, 0, 1'b0, 32'h0);
        do_xfer(1'b0, 1'b1, 3'b010, 32'hB000_0002, 32'h0, 0, 1'b0, 32'h5566_7788);
        do_xfer(1'b0, 1'b0, 3'b101, 32'hA000_0002, 32'h0, 0, 1'b1, 32'h8001_0000);

        // Reset asserted while a data phase is stalled
        req_valid = 1'b1; req_write = 1'b0; req_instr = 1'b0;
        req_fn3 = 3'b010; req_addr = 32'hB000_0004;
        @(posedge hclk);
        @(negedge hclk);
        req_valid = 1'b0;
        @(negedge hclk);
        hreadyout_s[1] = 1'b0;
        #1;
        check_eq("stall_hready", 32'(hready), 32'd0);
        #1 hresetn = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge hclk);
        hresetn = 1'b1;
        slaves_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge hclk);
            #1;
            check_eq("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        end
        do_xfer(1'b0, 1'b0, 3'b010, 32'hB000_0004, 32'h0, 0, 1'b0, 32'hCAFE_F00D);

        // Randomised traffic, back-to-back or with idle gaps
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       top = 8'hA0;
                1:       top = 8'hB0;
                2:       top = 8'hC0;
                default: top = 8'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(negedge hclk);
                #1;
            end
            do_xfer(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                    {top, 24'($urandom)}, $urandom, $urandom_range(0, 3),
                    ($urandom_range(0, 7) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
